// File: rtl/mul_req_arbiter_if.sv
// Bundles the two requester channels, the multiplier issue/return bus and the
// two result channels of mul_req_arbiter.
interface mul_req_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_operand_a;
    logic [31:0] req0_operand_b;
    logic [1:0]  req0_opcode;
    logic [1:0]  req0_precision;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_operand_a;
    logic [31:0] req1_operand_b;
    logic [1:0]  req1_opcode;
    logic [1:0]  req1_precision;

    logic [31:0] mul_operand_a_reg;
    logic [31:0] mul_operand_b_reg;
    logic [1:0]  mul_opcode_reg;
    logic [1:0]  mul_precision_reg;
    logic [31:0] mul_out;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_data;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_data;

    logic        busy;

    modport slave (
        input  req0_valid, req0_operand_a, req0_operand_b, req0_opcode, req0_precision,
        output req0_ready,
        input  req1_valid, req1_operand_a, req1_operand_b, req1_opcode, req1_precision,
        output req1_ready,
        output mul_operand_a_reg, mul_operand_b_reg, mul_opcode_reg, mul_precision_reg,
        input  mul_out,
        output rsp0_valid, rsp0_data,
        input  rsp0_ready,
        output rsp1_valid, rsp1_data,
        input  rsp1_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_operand_a, req0_operand_b, req0_opcode, req0_precision,
        input  req0_ready,
        output req1_valid, req1_operand_a, req1_operand_b, req1_opcode, req1_precision,
        input  req1_ready,
        input  mul_operand_a_reg, mul_operand_b_reg, mul_opcode_reg, mul_precision_reg,
        output mul_out,
        input  rsp0_valid, rsp0_data,
        output rsp0_ready,
        input  rsp1_valid, rsp1_data,
        output rsp1_ready,
        input  busy
    );
endinterface

// File: rtl/mul_req_arbiter.sv
// Two-requester round-robin front end for a shared pipelined multiplier, with
// credit-based flow control and a per-requester result FIFO.
module mul_req_arbiter #(
    parameter int MUL_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    mul_req_arbiter_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    logic [1:0]    w_req_valid;
    logic [1:0]    w_rsp_ready;
    logic [1:0]    w_elig;
    logic [1:0]    w_grant;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [1:0]    w_nonempty;
    logic [31:0]   w_op_a [2];
    logic [31:0]   w_op_b [2];
    logic [1:0]    w_opc  [2];
    logic [1:0]    w_prec [2];
    logic          w_cap;
    logic          w_cap_id;

    logic          r_ptr;
    logic [CW-1:0] r_occ    [2];
    logic [CW-1:0] r_infl   [2];
    logic [AW-1:0] r_wr_ptr [2];
    logic [AW-1:0] r_rd_ptr [2];
    logic [31:0]   r_mem    [2][FIFO_DEPTH];

    logic [31:0]   r_mul_a;
    logic [31:0]   r_mul_b;
    logic [1:0]    r_mul_opc;
    logic [1:0]    r_mul_prec;

    logic [MUL_LATENCY:0] r_tag_vld;
    logic [MUL_LATENCY:0] r_tag_id;

    assign w_req_valid = {bus.req1_valid, bus.req0_valid};
    assign w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign w_op_a[0]   = bus.req0_operand_a;
    assign w_op_a[1]   = bus.req1_operand_a;
    assign w_op_b[0]   = bus.req0_operand_b;
    assign w_op_b[1]   = bus.req1_operand_b;
    assign w_opc[0]    = bus.req0_opcode;
    assign w_opc[1]    = bus.req1_opcode;
    assign w_prec[0]   = bus.req0_precision;
    assign w_prec[1]   = bus.req1_precision;

    // Credits come only from registered counts, so rspN_ready never reaches reqM_ready.
    always_comb begin
        w_elig = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_elig[n] = w_req_valid[n] &&
                        (({1'b0, r_occ[n]} + {1'b0, r_infl[n]}) < DEPTH_C);
        end
    end

    always_comb begin
        w_grant = 2'b00;
        if (!rst) begin
            if (&w_elig) begin
                w_grant = r_ptr ? 2'b10 : 2'b01;
            end else begin
                w_grant = w_elig;
            end
        end
    end

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|w_grant) begin
            r_ptr <= w_grant[0];
        end
    end

    // Issue stage: operands of the granted requester, zero on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_opc  <= '0;
            r_mul_prec <= '0;
        end else if (|w_grant) begin
            r_mul_a    <= w_grant[1] ? w_op_a[1] : w_op_a[0];
            r_mul_b    <= w_grant[1] ? w_op_b[1] : w_op_b[0];
            r_mul_opc  <= w_grant[1] ? w_opc[1]  : w_opc[0];
            r_mul_prec <= w_grant[1] ? w_prec[1] : w_prec[0];
        end else begin
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_opc  <= '0;
            r_mul_prec <= '0;
        end
    end

    assign bus.mul_operand_a_reg = r_mul_a;
    assign bus.mul_operand_b_reg = r_mul_b;
    assign bus.mul_opcode_reg    = r_mul_opc;
    assign bus.mul_precision_reg = r_mul_prec;

    // Tag stage 0 lines up with the issue register; stage MUL_LATENCY with mul_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= |w_grant;
            r_tag_id[0]  <= w_grant[1];
            r_tag_vld[MUL_LATENCY:1] <= r_tag_vld[MUL_LATENCY-1:0];
            r_tag_id[MUL_LATENCY:1]  <= r_tag_id[MUL_LATENCY-1:0];
        end
    end

    assign w_cap    = r_tag_vld[MUL_LATENCY];
    assign w_cap_id = r_tag_id[MUL_LATENCY];

    always_comb begin
        w_push     = 2'b00;
        w_pop      = 2'b00;
        w_nonempty = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_nonempty[n] = (r_occ[n] != '0);
            w_push[n]     = w_cap && (w_cap_id == 1'(n));
            w_pop[n]      = w_rsp_ready[n] && w_nonempty[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                r_occ[n]    <= '0;
                r_infl[n]   <= '0;
                r_wr_ptr[n] <= '0;
                r_rd_ptr[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                r_occ[n]  <= r_occ[n] + CW'(w_push[n]) - CW'(w_pop[n]);
                r_infl[n] <= r_infl[n] + CW'(w_grant[n]) - CW'(w_push[n]);
                if (w_push[n]) begin
                    r_wr_ptr[n] <= r_wr_ptr[n] + AW'(1);
                end
                if (w_pop[n]) begin
                    r_rd_ptr[n] <= r_rd_ptr[n] + AW'(1);
                end
            end
        end
    end

    // Storage is not reset: an empty FIFO masks its head to zero.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wr_ptr[n]] <= bus.mul_out;
            end
        end
    end

    assign bus.rsp0_valid = w_nonempty[0];
    assign bus.rsp1_valid = w_nonempty[1];
    assign bus.rsp0_data  = w_nonempty[0] ? r_mem[0][r_rd_ptr[0]] : '0;
    assign bus.rsp1_data  = w_nonempty[1] ? r_mem[1][r_rd_ptr[1]] : '0;

    assign bus.busy = (|w_nonempty) || (r_infl[0] != '0) || (r_infl[1] != '0);
endmodule

// File: tb/tb_mul_req_arbiter.sv
// Bench for mul_req_arbiter: emulated lane multiplier, result scoreboard,
// directed vector table and multi-cycle corner sequences.
module tb_mul_req_arbiter;
    localparam int L = 3;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_req_arbiter_if bus ();

    mul_req_arbiter #(.MUL_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] mmodel(input logic [1:0] op, input logic [1:0] pr,
                                           input logic [31:0] a, input logic [31:0] b);
        int          w;
        logic [31:0] res;
        logic [63:0] ax, bx, p, m, lane;
        w   = (pr == 2'b00) ? 8 : (pr == 2'b01) ? 16 : 32;
        res = '0;
        m   = (64'd1 << w) - 64'd1;
        for (int l = 0; l < 32 / w; l++) begin
            ax = ({32'd0, a} >> (l * w)) & m;
            bx = ({32'd0, b} >> (l * w)) & m;
            if ((op == 2'b01 || op == 2'b11) && ax[w-1]) ax = ax | ~m;
            if (op == 2'b01 && bx[w-1]) bx = bx | ~m;
            p    = ax * bx;
            lane = ((op == 2'b00) ? p : (p >> w)) & m;
            res  = res | 32'(lane << (l * w));
        end
        return res;
    endfunction

    // Emulated multiplier: L-cycle pipeline behind the issue registers.
    logic [31:0] mpipe [L];
    always @(posedge clk) begin
        mpipe[0] <= mmodel(bus.mul_opcode_reg, bus.mul_precision_reg,
                           bus.mul_operand_a_reg, bus.mul_operand_b_reg);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign bus.mul_out = mpipe[L-1];

    function automatic logic rdy(input int n);
        return (n == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction
    function automatic logic rspv(input int n);
        return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction
    function automatic logic [31:0] rspd(input int n);
        return (n == 0) ? bus.rsp0_data : bus.rsp1_data;
    endfunction

    task automatic set_req(input int n, input logic v, input logic [1:0] op, input logic [1:0] pr,
                           input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_opcode = op; bus.req0_precision = pr;
            bus.req0_operand_a = a; bus.req0_operand_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_opcode = op; bus.req1_precision = pr;
            bus.req1_operand_a = a; bus.req1_operand_b = b;
        end
    endtask

    // Scoreboard: expected results queued at transfer, matched at pop.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        hold0 = 1'b0, hold1 = 1'b0;
    logic [31:0] prev0, prev1;

    always @(negedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete();
            hold0 = 1'b0; hold1 = 1'b0;
        end else begin
            check("one_grant", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (hold0 && bus.rsp0_valid) check("rsp0_stable", bus.rsp0_data, prev0);
            if (hold1 && bus.rsp1_valid) check("rsp1_stable", bus.rsp1_data, prev1);
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp0_unexpected: got 0x%08h, expected no result", bus.rsp0_data);
                end else check("rsp0_order", bus.rsp0_data, q0.pop_front());
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp1_unexpected: got 0x%08h, expected no result", bus.rsp1_data);
                end else check("rsp1_order", bus.rsp1_data, q1.pop_front());
            end
            if (bus.req0_valid && bus.req0_ready) begin
                q0.push_back(mmodel(bus.req0_opcode, bus.req0_precision,
                                    bus.req0_operand_a, bus.req0_operand_b));
                check("occ0_bound", 32'(q0.size() <= D), 32'd1);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                q1.push_back(mmodel(bus.req1_opcode, bus.req1_precision,
                                    bus.req1_operand_a, bus.req1_operand_b));
                check("occ1_bound", 32'(q1.size() <= D), 32'd1);
            end
            hold0 = bus.rsp0_valid && !bus.rsp0_ready; prev0 = bus.rsp0_data;
            hold1 = bus.rsp1_valid && !bus.rsp1_ready; prev1 = bus.rsp1_data;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'd0);
        check({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'd0);
        check({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 32'd0);
        check({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 32'd0);
        check({tag, "_rsp0_data"}, bus.rsp0_data, 32'd0);
        check({tag, "_rsp1_data"}, bus.rsp1_data, 32'd0);
        check({tag, "_mul_a"}, bus.mul_operand_a_reg, 32'd0);
        check({tag, "_mul_b"}, bus.mul_operand_b_reg, 32'd0);
        check({tag, "_mul_ctl"}, {28'd0, bus.mul_opcode_reg, bus.mul_precision_reg}, 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        set_req(0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_q0_empty"}, 32'(q0.size()), 32'd0);
        check({tag, "_q1_empty"}, 32'(q1.size()), 32'd0);
    endtask

    typedef struct {
        int          req;
        logic [1:0]  op;
        logic [1:0]  pr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
    } vec_t;
    vec_t vecs [12];

    task automatic run_vec(input vec_t v);
        int j;
        @(posedge clk);
        #1 set_req(v.req, 1'b1, v.op, v.pr, v.a, v.b);
        @(negedge clk);
        check("vec_ready", 32'(rdy(v.req)), 32'd1);
        @(posedge clk);
        #1 set_req(v.req, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        j = 0;
        @(negedge clk);
        while (!rspv(v.req) && j < 12) begin
            @(negedge clk);
            j++;
        end
        check("vec_latency", j, 4);
        check("vec_data", rspd(v.req), v.expv);
        check("vec_other_idle", 32'(rspv(1 - v.req)), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, nv;
        logic [31:0] a0, a1;
        logic x0, x1;

        vecs[0]  = '{0, 2'b00, 2'b00, 32'h02030405, 32'h02020202, 32'h0406080A};
        vecs[1]  = '{1, 2'b10, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{0, 2'b00, 2'b10, 32'h00001234, 32'h00000010, 32'h00012340};
        vecs[3]  = '{1, 2'b01, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[4]  = '{0, 2'b11, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5]  = '{1, 2'b00, 2'b01, 32'h0003FFFF, 32'h00040002, 32'h000CFFFE};
        vecs[6]  = '{0, 2'b01, 2'b01, 32'h80007FFF, 32'h80007FFF, 32'h40003FFF};
        vecs[7]  = '{1, 2'b10, 2'b00, 32'hFFFF1001, 32'hFF021001, 32'hFE010100};
        vecs[8]  = '{0, 2'b01, 2'b00, 32'h80FF7F01, 32'h80017FFF, 32'h40FF3FFF};
        vecs[9]  = '{1, 2'b11, 2'b00, 32'hFF800200, 32'hFFFF8005, 32'hFF800100};
        vecs[10] = '{0, 2'b11, 2'b01, 32'hFFFF0002, 32'hFFFF8000, 32'hFFFF0001};
        vecs[11] = '{1, 2'b10, 2'b01, 32'hFFFF1234, 32'h00020100, 32'h00010012};

        // Reset state with both requesters asserting valid, then round-robin.
        set_req(0, 1'b1, 2'b00, 2'b10, 32'd11, 32'd2);
        set_req(1, 1'b1, 2'b00, 2'b10, 32'd13, 32'd3);
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_grant", {30'd0, bus.req1_ready, bus.req0_ready},
                  (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        @(posedge clk);
        #1 wait_idle("rr");

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);
        wait_idle("vec");

        // Result backpressure on requester 0 while requester 1 keeps flowing.
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
        do_reset();
        a0 = 32'h100; a1 = 32'h200;
        set_req(0, 1'b1, 2'b00, 2'b10, a0, 32'd3);
        set_req(1, 1'b1, 2'b00, 2'b10, a1, 32'd5);
        g0 = 0; g1 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            x0 = bus.req0_ready; x1 = bus.req1_ready;
            g0 += int'(x0); g1 += int'(x1);
            @(posedge clk);
            #1;
            if (x0) begin a0++; bus.req0_operand_a = a0; end
            if (x1) begin a1++; bus.req1_operand_a = a1; end
        end
        check("bp_req0_grants", g0, 4);
        check("bp_req1_progress", 32'(g1 >= 12), 32'd1);
        check("bp_rsp0_full", 32'(bus.rsp0_valid), 32'd1);
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_req0_blocked", 32'(bus.req0_ready), 32'd0);
        x1 = bus.req1_ready;
        @(posedge clk);
        #1 if (x1) begin a1++; bus.req1_operand_a = a1; end
        @(negedge clk);
        check("bp_req0_reenabled", 32'(bus.req0_ready), 32'd1);
        @(posedge clk);
        #1 wait_idle("bp");

        // Reset with one result buffered and two operations in flight.
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
        do_reset();
        set_req(0, 1'b1, 2'b00, 2'b10, 32'd5, 32'd7);
        @(posedge clk);
        #1 set_req(0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mid_buffered", 32'(bus.rsp0_valid), 32'd1);
        @(posedge clk);
        #1 set_req(0, 1'b1, 2'b00, 2'b10, 32'd9, 32'd9);
        @(posedge clk);
        #1 set_req(0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b1, 2'b00, 2'b10, 32'd3, 32'd4);
        @(posedge clk);
        #1 set_req(1, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        check("mid_issue_before", bus.mul_operand_a_reg, 32'd3);
        rst = 1'b1;
        set_req(0, 1'b1, 2'b00, 2'b10, 32'd1, 32'd1);
        set_req(1, 1'b1, 2'b00, 2'b10, 32'd1, 32'd1);
        #1 check_reset_outputs("mid_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_held");
        set_req(0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            nv += int'(bus.rsp0_valid) + int'(bus.rsp1_valid);
        end
        check("mid_no_stale", nv, 0);
        check("mid_busy_after", 32'(bus.busy), 32'd0);

        // Random traffic with random result backpressure.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            x0 = bus.req0_valid && bus.req0_ready;
            x1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk);
            #1;
            if (!bus.req0_valid || x0)
                set_req(0, $urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 2)), $urandom, $urandom);
            if (!bus.req1_valid || x1)
                set_req(1, $urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)),
                        2'($urandom_range(0, 2)), $urandom, $urandom);
            bus.rsp0_ready = $urandom_range(0, 99) < 50;
            bus.rsp1_ready = $urandom_range(0, 99) < 50;
        end
        @(negedge clk);
        x0 = bus.req0_valid && bus.req0_ready;
        x1 = bus.req1_valid && bus.req1_ready;
        @(posedge clk);
        #1 wait_idle("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
